// File: rtl/clock_switch_ctrl.sv
// Break-before-make sequencer for a glitch-free clock mux select vector.
// Runs on an always-on reference clock; falls back to DEFAULT_SEL when the active source dies.
module clock_switch_ctrl #(
  parameter int N           = 2,
  parameter int IW          = $clog2(N),
  parameter int SETTLE      = 8,
  parameter int TIMEOUT     = 64,
  parameter int DEFAULT_SEL = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic [IW-1:0] req_sel,
  input  logic [N-1:0]  clk_ok,
  output logic [N-1:0]  select,
  output logic [IW-1:0] cur_sel,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int CMAX = (SETTLE > TIMEOUT) ? SETTLE : TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [IW-1:0] DEF = IW'(DEFAULT_SEL);

  typedef enum logic [2:0] {IDLE, OFF, WAIT_OK, ON, FINISH} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [IW-1:0] target, target_nx, prev, prev_nx;
  logic          abort, abort_nx, fb, fb_nx;
  logic [N-1:0]  select_nx;
  logic [IW-1:0] cur_sel_nx;
  logic          busy_nx, done_nx, err_nx;
  logic          fallback, req_legal, target_ok;

  function automatic logic [N-1:0] onehot(input logic [IW-1:0] idx);
    onehot = {{(N-1){1'b0}}, 1'b1} << idx;
  endfunction

  assign fallback  = (clk_ok[cur_sel] == 1'b0) && (cur_sel != DEF);
  assign req_legal = (int'(req_sel) < N);
  // A fallback target is trusted without qualification.
  assign target_ok = fb || clk_ok[target];

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      target  <= DEF;
      prev    <= DEF;
      abort   <= 1'b0;
      fb      <= 1'b0;
      select  <= onehot(DEF);
      cur_sel <= DEF;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      target  <= target_nx;
      prev    <= prev_nx;
      abort   <= abort_nx;
      fb      <= fb_nx;
      select  <= select_nx;
      cur_sel <= cur_sel_nx;
      busy    <= busy_nx;
      done    <= done_nx;
      err     <= err_nx;
    end
  end

  // Next-state logic; the first qualification happens as the off phase ends.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    target_nx = target;
    prev_nx   = prev;
    abort_nx  = abort;
    fb_nx     = fb;
    case (state)
      IDLE: begin
        if (fallback) begin
          target_nx = DEF;
          prev_nx   = cur_sel;
          fb_nx     = 1'b1;
          abort_nx  = 1'b0;
          cnt_nx    = '0;
          state_nx  = OFF;
        end else if (req_valid && req_legal && (req_sel != cur_sel)) begin
          target_nx = req_sel;
          prev_nx   = cur_sel;
          fb_nx     = 1'b0;
          abort_nx  = 1'b0;
          cnt_nx    = '0;
          state_nx  = OFF;
        end else begin
          state_nx = IDLE;
        end
      end
      OFF: begin
        if (cnt == CW'(SETTLE - 1)) begin
          cnt_nx   = '0;
          state_nx = target_ok ? ON : WAIT_OK;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      WAIT_OK: begin
        if (target_ok) begin
          cnt_nx   = '0;
          state_nx = ON;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          cnt_nx   = '0;
          abort_nx = 1'b1;
          state_nx = ON;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      ON: begin
        if (cnt == CW'(SETTLE - 1)) begin
          cnt_nx   = '0;
          state_nx = FINISH;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      FINISH: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    select_nx  = select;
    cur_sel_nx = cur_sel;
    busy_nx    = (state_nx == OFF) || (state_nx == WAIT_OK) || (state_nx == ON);
    done_nx    = 1'b0;
    err_nx     = 1'b0;
    case (state)
      IDLE: begin
        if (fallback) begin
          select_nx = '0;
        end else if (req_valid) begin
          if (!req_legal) begin
            err_nx = 1'b1;
          end else if (req_sel == cur_sel) begin
            done_nx = 1'b1;
          end else begin
            select_nx = '0;
          end
        end else begin
          select_nx = select;
        end
      end
      OFF, WAIT_OK: begin
        if (state_nx == ON) begin
          select_nx = abort_nx ? onehot(prev) : onehot(target);
        end else begin
          select_nx = '0;
        end
      end
      ON: begin
        if (state_nx == FINISH) begin
          if (abort) begin
            err_nx = 1'b1;
          end else begin
            done_nx    = 1'b1;
            cur_sel_nx = target;
          end
        end else begin
          done_nx = 1'b0;
        end
      end
      FINISH: begin
        done_nx = 1'b0;
      end
      default: begin
        select_nx = onehot(DEF);
      end
    endcase
  end

endmodule
